// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic input feeder.
//   feeder_state_t : run sequencer states
//   BANK_A/BANK_B  : wr_sel encodings
//   feed_len()     : number of FEED cycles for an N x N array
//   idx_width()    : index width for a range of n values, never below 1 bit
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN
  } feeder_state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // Streaming window: the last lane starts N-1 cycles late and the last
  // product needs another N-1 cycles to cross the array.
  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed feed lane. Given a row (or column) vector and its lane index,
// outputs vec[t - lane] while that offset lies inside the vector and the
// feed window is open, else 0. The element is registered.
// Ports:
//   clk, reset : clock, async active-high reset
//   vec        : N elements the lane selects from
//   lane       : this lane's index (delay in cycles)
//   t          : feed count for the cycle the output will be visible in
//   valid      : feed window open in that cycle
//   elem       : registered selected element
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_SIZE   = 8,
  parameter int T_W         = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] vec [MATRIX_SIZE],
  input  logic [T_W-1:0]       lane,
  input  logic [T_W-1:0]       t,
  input  logic                 valid,
  output logic [DATA_SIZE-1:0] elem
);

  localparam int IDX_W = idx_width(MATRIX_SIZE);

  logic [T_W-1:0]       offset;
  logic                 in_range;
  logic [IDX_W-1:0]     sel;
  logic [DATA_SIZE-1:0] elem_d;

  // Unsigned subtraction wraps when t < lane, so the lower bound is
  // checked explicitly rather than relying on the upper one.
  always_comb begin
    offset   = t - lane;
    in_range = valid && (t >= lane) && (offset < T_W'(MATRIX_SIZE));
    sel      = offset[IDX_W-1:0];
    elem_d   = in_range ? vec[sel] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) elem <= '0;
    else       elem <= elem_d;
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// Upstream stage of an N x N systolic multiplier. Holds operand banks A and
// B (written one row per cycle while idle), then streams them into the
// array edges with lane i delayed by i cycles, pulsing array_clear first
// and run_done at the end of the drain period.
// Ports:
//   clk, reset          : clock, async active-high reset
//   wr_en/wr_sel/wr_row : row write strobe, bank select, row index
//   wr_data             : row contents, wr_data[k] = element (wr_row,k)
//   wr_ready            : high only while idle
//   start               : begin a run (idle only)
//   busy                : high in CLEAR, FEED, DRAIN
//   array_clear         : one-cycle clear pulse for the multiplier
//   feed_a, feed_b      : skewed operands to the array's in_a / in_b
//   run_done            : one-cycle pulse in the last drain cycle
module systolic_input_feeder
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE  = 16,
  parameter int DATA_SIZE    = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic                             wr_sel,
  input  logic [idx_width(MATRIX_SIZE)-1:0] wr_row,
  input  logic [DATA_SIZE-1:0]             wr_data [MATRIX_SIZE],
  output logic                             wr_ready,
  input  logic                             start,
  output logic                             busy,
  output logic                             array_clear,
  output logic [DATA_SIZE-1:0]             feed_a [MATRIX_SIZE],
  output logic [DATA_SIZE-1:0]             feed_b [MATRIX_SIZE],
  output logic                             run_done
);

  localparam int N         = MATRIX_SIZE;
  localparam int FEED_LEN  = feed_len(N);
  localparam int T_W       = idx_width(FEED_LEN);
  // A zero-length drain still needs one cycle to carry run_done.
  localparam int DRAIN_LEN = (DRAIN_CYCLES > 1) ? DRAIN_CYCLES : 1;
  localparam int D_W       = idx_width(DRAIN_LEN);

  localparam logic [T_W-1:0] T_LAST = T_W'(FEED_LEN - 1);
  localparam logic [D_W-1:0] D_LAST = D_W'(DRAIN_LEN - 1);

  feeder_state_t state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic [D_W-1:0] drain_q, drain_d;
  logic           feed_valid_d;
  logic           array_clear_d;
  logic           run_done_d;

  logic [DATA_SIZE-1:0] bank_a [N][N];
  logic [DATA_SIZE-1:0] bank_b [N][N];
  logic [DATA_SIZE-1:0] b_col  [N][N];

  // Every output is a register, so this block computes next-cycle values;
  // the lanes are fed t_d/feed_valid_d for the same reason.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    t_d           = t_q;
    drain_d       = drain_q;
    feed_valid_d  = 1'b0;
    array_clear_d = 1'b0;
    run_done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = CLEAR;
          array_clear_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d      = FEED;
        t_d          = '0;
        feed_valid_d = 1'b1;
      end
      FEED: begin
        if (t_q == T_LAST) begin
          state_d    = DRAIN;
          t_d        = '0;
          drain_d    = '0;
          run_done_d = (DRAIN_LEN == 1);
        end else begin
          t_d          = t_q + 1'b1;
          feed_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == D_LAST) begin
          state_d = IDLE;
          drain_d = '0;
        end else begin
          drain_d    = drain_q + 1'b1;
          run_done_d = ((drain_q + 1'b1) == D_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      drain_q     <= '0;
      array_clear <= 1'b0;
      run_done    <= 1'b0;
      wr_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      drain_q     <= drain_d;
      array_clear <= array_clear_d;
      run_done    <= run_done_d;
      wr_ready    <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
    end
  end

  // NOTE: the banks must read as zero after reset, so they are flops with a
  // reset rather than a RAM; storage without that need would omit it.
  // A write coinciding with start lands on the start edge, before the first
  // lane sample one edge later, so the run sees it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          bank_a[r][c] <= '0;
          bank_b[r][c] <= '0;
        end
      end
    end else if (state_q == IDLE && wr_en) begin
      if (wr_sel == BANK_A) bank_a[wr_row] <= wr_data;
      else                  bank_b[wr_row] <= wr_data;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    // B lanes walk down a column, so present each column as a vector.
    for (genvar k = 0; k < N; k++) begin : g_col
      assign b_col[g][k] = bank_b[k][g];
    end

    systolic_skew_lane #(
      .MATRIX_SIZE(N),
      .DATA_SIZE  (DATA_SIZE),
      .T_W        (T_W)
    ) u_lane_a (
      .clk  (clk),
      .reset(reset),
      .vec  (bank_a[g]),
      .lane (T_W'(g)),
      .t    (t_d),
      .valid(feed_valid_d),
      .elem (feed_a[g])
    );

    systolic_skew_lane #(
      .MATRIX_SIZE(N),
      .DATA_SIZE  (DATA_SIZE),
      .T_W        (T_W)
    ) u_lane_b (
      .clk  (clk),
      .reset(reset),
      .vec  (b_col[g]),
      .lane (T_W'(g)),
      .t    (t_d),
      .valid(feed_valid_d),
      .elem (feed_b[g])
    );
  end

endmodule
